// File: rtl/keypad_if.sv
`default_nettype none
// ============================================================================
// keypad_if : row/col/strobe inputs and decoded key outputs of the keypad
// Rev 1.0
// ============================================================================
interface keypad_if #(
  parameter int KEY_ROW = 4,
  parameter int KEY_COL = 4
) ();
  logic [KEY_ROW-1:0] row;
  logic [KEY_COL-1:0] col;
  logic               key_in;
  logic [KEY_ROW-1:0] key;
  logic               valid;

  modport master (output row, output col, output key_in, input key, input valid);
  modport slave  (input row, input col, input key_in, output key, output valid);
endinterface
`default_nettype wire

// File: rtl/keypad.sv
`default_nettype none
// ============================================================================
// keypad : debounced 4x4 matrix keypad decoder with registered key/valid
// Rev 1.0
// ============================================================================
module keypad #(
  parameter int KEY_ROW      = 4,
  parameter int KEY_COL      = 4,
  parameter int DEBOUNCE_CYC = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  keypad_if.slave   bus_io
);

  localparam int CNT_W = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_COMMIT = CNT_W'(DEBOUNCE_CYC);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_ROW-1:0] row_q, row_d;
  logic [KEY_COL-1:0] col_q, col_d;
  logic [KEY_ROW-1:0] key_q, key_d;
  logic               valid_q, valid_d;

  logic [1:0]         w_row_idx;
  logic [1:0]         w_col_idx;
  logic               w_legal;
  logic [3:0]         w_code;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_commit;

  assign w_legal   = $onehot(bus_io.row) && $onehot(bus_io.col);
  assign w_cnt_inc = cnt_q + C_CNT_ONE;

  always_comb begin
    w_row_idx = 2'd0;
    w_col_idx = 2'd0;
    for (int i = 0; i < KEY_ROW; i++) begin
      if (bus_io.row[i]) w_row_idx = i[1:0];
    end
    for (int j = 0; j < KEY_COL; j++) begin
      if (bus_io.col[j]) w_col_idx = j[1:0];
    end
  end

  // Layout: 1 2 3 + / 4 5 6 - / 7 8 9 * / 0 C = /
  always_comb begin
    w_code = 4'd0;
    unique case ({w_row_idx, w_col_idx})
      4'b00_00: w_code = 4'd1;
      4'b00_01: w_code = 4'd2;
      4'b00_10: w_code = 4'd3;
      4'b00_11: w_code = 4'd10;
      4'b01_00: w_code = 4'd4;
      4'b01_01: w_code = 4'd5;
      4'b01_10: w_code = 4'd6;
      4'b01_11: w_code = 4'd11;
      4'b10_00: w_code = 4'd7;
      4'b10_01: w_code = 4'd8;
      4'b10_10: w_code = 4'd9;
      4'b10_11: w_code = 4'd12;
      4'b11_00: w_code = 4'd0;
      4'b11_01: w_code = 4'd14;
      4'b11_10: w_code = 4'd15;
      4'b11_11: w_code = 4'd13;
      default:  w_code = 4'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    col_d    = col_q;
    key_d    = key_q;
    valid_d  = valid_q;
    w_commit = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus_io.key_in) begin
          row_d = bus_io.row;
          col_d = bus_io.col;
          cnt_d = C_CNT_ONE;
          if (DEBOUNCE_CYC == 1) begin
            w_commit = 1'b1;
            state_d  = S_PRESSED;
          end else begin
            state_d  = S_DEBOUNCE;
          end
        end
      end
      S_DEBOUNCE: begin
        if (!bus_io.key_in) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if ((bus_io.row != row_q) || (bus_io.col != col_q)) begin
          row_d = bus_io.row;
          col_d = bus_io.col;
          cnt_d = C_CNT_ONE;
        end else begin
          cnt_d = w_cnt_inc;
          if (w_cnt_inc == C_CNT_COMMIT) begin
            w_commit = 1'b1;
            state_d  = S_PRESSED;
          end
        end
      end
      S_PRESSED: begin
        // Only release matters here; one commit per press.
        if (!bus_io.key_in) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Inputs equal the captured value on any commit edge, so decode them directly.
    if (w_commit) begin
      key_d   = w_legal ? KEY_ROW'(w_code) : '0;
      valid_d = w_legal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      key_q   <= key_d;
      valid_q <= valid_d;
    end
  end

  assign bus_io.key   = key_q;
  assign bus_io.valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad.sv
`default_nettype none
// ============================================================================
// tb_keypad : directed vector table plus randomized run against a press model
// Rev 1.0
// ============================================================================
module tb_keypad;

  localparam int DEB = 2;

  logic clk;
  logic rst;

  keypad_if #(.KEY_ROW(4), .KEY_COL(4)) kp ();

  keypad #(.KEY_ROW(4), .KEY_COL(4), .DEBOUNCE_CYC(DEB)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (kp)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ki;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] ek;
    logic       ev;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: counts consecutive identical held samples since press start.
  string      layout = "123+456-789*0C=/";
  int         m_run;
  bit         m_done;
  logic [3:0] m_last_row, m_last_col;
  logic [3:0] m_key;
  logic       m_valid;

  function automatic logic [3:0] char_code(input byte ch);
    if (ch >= "0" && ch <= "9") return 4'(ch - "0");
    case (ch)
      "+":     return 4'd10;
      "-":     return 4'd11;
      "*":     return 4'd12;
      "/":     return 4'd13;
      "C":     return 4'd14;
      "=":     return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  task automatic model_commit(input logic [3:0] rw, input logic [3:0] cl);
    int r, c;
    r = 0;
    c = 0;
    if ($countones(rw) == 1 && $countones(cl) == 1) begin
      for (int i = 0; i < 4; i++) begin
        if (rw[i]) r = i;
        if (cl[i]) c = i;
      end
      m_key   = char_code(layout[r*4 + c]);
      m_valid = 1'b1;
    end else begin
      m_key   = 4'd0;
      m_valid = 1'b0;
    end
  endtask

  task automatic model_step(input logic r, input logic k, input logic [3:0] rw, input logic [3:0] cl);
    if (r) begin
      m_run = 0; m_done = 0; m_key = 4'd0; m_valid = 1'b0;
    end else if (!k) begin
      m_run = 0; m_done = 0;
    end else if (!m_done) begin
      if (m_run > 0 && rw == m_last_row && cl == m_last_col) m_run++;
      else m_run = 1;
      m_last_row = rw;
      m_last_col = cl;
      if (m_run == DEB) begin
        model_commit(rw, cl);
        m_done = 1;
      end
    end
  endtask

  task automatic apply(input logic r, input logic k, input logic [3:0] rw, input logic [3:0] cl);
    rst       = r;
    kp.key_in = k;
    kp.row    = rw;
    kp.col    = cl;
    model_step(r, k, rw, cl);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [3:0] ek, input logic ev);
    checks++;
    if (kp.key !== ek || kp.valid !== ev) begin
      errors++;
      $display("FAIL %s: key=%0d valid=%0b, expected key=%0d valid=%0b",
               name, kp.key, kp.valid, ek, ev);
    end
  endtask

  task automatic add(input logic r, input logic k, input logic [3:0] rw, input logic [3:0] cl,
                     input logic [3:0] ek, input logic ev, input string name);
    vec_t v;
    v.rst = r; v.ki = k; v.row = rw; v.col = cl; v.ek = ek; v.ev = ev; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] rrow, rcol;
    logic       rki, rrst;

    rst = 1'b1; kp.key_in = 1'b0; kp.row = '0; kp.col = '0;
    m_run = 0; m_done = 0; m_key = '0; m_valid = 1'b0; m_last_row = '0; m_last_col = '0;

    //   rst ki  row      col      key valid name
    add(1, 0, 4'b0000, 4'b0000,  0, 0, "reset0");
    add(1, 0, 4'b0000, 4'b0000,  0, 0, "reset1");
    add(0, 1, 4'b0001, 4'b0010,  0, 0, "deb_first");
    add(0, 1, 4'b0001, 4'b0010,  2, 1, "commit_2");
    add(0, 1, 4'b0001, 4'b0010,  2, 1, "hold_2");
    add(0, 0, 4'b0000, 4'b0000,  2, 1, "release_2");
    add(0, 1, 4'b1000, 4'b0100,  2, 1, "eq_first");
    add(0, 1, 4'b1000, 4'b0100, 15, 1, "commit_eq");
    add(0, 0, 4'b1000, 4'b0100, 15, 1, "release_eq");
    add(0, 1, 4'b0110, 4'b0001, 15, 1, "tworow_first");
    add(0, 1, 4'b0110, 4'b0001,  0, 0, "tworow_illegal");
    add(0, 0, 4'b0000, 4'b0000,  0, 0, "release_illegal");
    add(0, 1, 4'b0000, 4'b0000,  0, 0, "nokey_first");
    add(0, 1, 4'b0000, 4'b0000,  0, 0, "nokey_illegal");
    add(0, 0, 4'b0000, 4'b0000,  0, 0, "release_nokey");
    add(0, 1, 4'b0010, 4'b0100,  0, 0, "six_first");
    add(0, 1, 4'b0010, 4'b0100,  6, 1, "commit_6");
    add(0, 0, 4'b0000, 4'b0000,  6, 1, "release_6");
    add(0, 1, 4'b0001, 4'b0001,  6, 1, "bounce_high");
    add(0, 0, 4'b0001, 4'b0001,  6, 1, "bounce_low");
    add(0, 0, 4'b0000, 4'b0000,  6, 1, "bounce_nocommit");
    add(0, 1, 4'b0001, 4'b0001,  6, 1, "restart_first");
    add(0, 1, 4'b0001, 4'b0010,  6, 1, "restart_change");
    add(0, 1, 4'b0001, 4'b0010,  2, 1, "restart_commit");
    add(0, 0, 4'b0000, 4'b0000,  2, 1, "release_restart");
    add(0, 1, 4'b1000, 4'b1000,  2, 1, "div_first");
    add(0, 1, 4'b1000, 4'b1000, 13, 1, "commit_div");
    add(0, 1, 4'b0001, 4'b0001, 13, 1, "pressed_ignore");
    add(1, 1, 4'b1000, 4'b1000,  0, 0, "reset_pressed");
    add(0, 1, 4'b1000, 4'b1000,  0, 0, "repress_first");
    add(0, 1, 4'b1000, 4'b1000, 13, 1, "repress_commit");
    add(0, 0, 4'b0000, 4'b0000, 13, 1, "release_div");
    add(0, 1, 4'b0100, 4'b0001, 13, 1, "seven_first");
    add(1, 1, 4'b0100, 4'b0001,  0, 0, "reset_debounce");
    add(0, 1, 4'b0100, 4'b0001,  0, 0, "seven_again");
    add(0, 1, 4'b0100, 4'b0001,  7, 1, "commit_7");

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].ki, vecs[i].row, vecs[i].col);
      check(vecs[i].name, vecs[i].ek, vecs[i].ev);
    end

    rrow = 4'b0001; rcol = 4'b0001; rki = 1'b0;
    for (int n = 0; n < 600; n++) begin
      rrst = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) rki = ~rki;
      case ($urandom_range(0, 9))
        0:       rrow = 4'b0001 << $urandom_range(0, 3);
        1:       rcol = 4'b0001 << $urandom_range(0, 3);
        2:       begin rrow = 4'($urandom); rcol = 4'($urandom); end
        default: ;
      endcase
      apply(rrst, rki, rrow, rcol);
      check("random", m_key, m_valid);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
